lsu_align: RTL and testbench

- Load/store alignment stage directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address, plus the store data and funct3.
- Runs one transaction on a valid/ready word-wide data-memory port, with byte/halfword lane steering and strobes.
- Returns sign- or zero-extended load data, or an error, as a one-cycle response to writeback.

---
 rtl/lsu_align.sv | 162 ++++++++++++++++
 tb/tb_lsu_align.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// RV32I load/store alignment stage: steers byte/halfword lanes onto a word-wide
// valid/ready memory port and returns extended load data or an error response.
module lsu_align #(
  parameter bit STRICT_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic        req_legal, req_aligned;
  logic [3:0]  req_wstrb;
  logic [31:0] req_lanes;
  logic [31:0] rdata_shift;
  logic [15:0] rdata_half;
  logic [31:0] load_ext;

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    req_legal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_we;
      default:                req_legal = 1'b0;
    endcase

    req_aligned = 1'b1;
    if (STRICT_ALIGN) begin
      unique case (req_funct3[1:0])
        2'b01:   req_aligned = !req_addr[0];
        2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
        default: req_aligned = 1'b1;
      endcase
    end

    req_wstrb = 4'b1111;
    req_lanes = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        req_wstrb = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!req_we) req_wstrb = 4'b0000;
  end

  // Load extraction uses the captured funct3 and lane offset.
  always_comb begin
    rdata_shift = mem_rdata >> {off_q, 3'b000};
    rdata_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b100:  load_ext = {24'h0, rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_half[15]}}, rdata_half};
      3'b101:  load_ext = {16'h0, rdata_half};
      default: load_ext = mem_rdata;
    endcase
    if (mem_we_q) load_ext = 32'h0;
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wstrb_d = req_wstrb;
          mem_wdata_d = req_lanes;
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          rsp_rdata_d = 32'h0;
          rsp_error_d = !(req_legal && req_aligned);
          state_d     = (req_legal && req_aligned) ? StBusy : StDone;
        end
      end
      StBusy: begin
        if (mem_ready) begin
          rsp_rdata_d = load_ext;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
      funct3_q    <= 3'h0;
      off_q       <= 2'h0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_valid = (state_q == StBusy);
  assign rsp_valid = (state_q == StDone);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: expected responses are queued at request time
// and compared when rsp_valid fires, along with memory-port and latency checks.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  lsu_align #(.STRICT_ALIGN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one request and services the memory port; mem_ready rises after
  // `delay` wait cycles of mem_valid. Latency counted in cycles from acceptance.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay,
                         input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    rsp_t exp_rsp;
    rsp_t got;
    int   exp_lat;
    bit   seen;
    exp_lat = exp_err ? 1 : 2 + delay;
    @(negedge clk);
    check_eq({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_rdata  = rdata;
    exp_rsp.rdata = exp_rdata;
    exp_rsp.error = exp_err;
    rsp_q.push_back(exp_rsp);
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5555_5555;
      check_eq({tag, " mem_valid"}, 32'(mem_valid),
               32'(!exp_err && k <= 1 + delay));
      if (k == 1 && !exp_err) begin
        check_eq({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check_eq({tag, " mem_we"}, 32'(mem_we), 32'(we));
        check_eq({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
        if (we) check_eq({tag, " mem_wdata"}, mem_wdata, exp_wdata);
      end
      mem_ready = (k == 1 + delay) && !exp_err;
      if (rsp_valid) begin
        seen = 1'b1;
        check_eq({tag, " latency"}, k, exp_lat);
        if (rsp_q.size() == 0) begin
          check_eq({tag, " unexpected rsp"}, 32'd1, 32'd0);
        end else begin
          got = rsp_q.pop_front();
          check_eq({tag, " rsp_rdata"}, rsp_rdata, got.rdata);
          check_eq({tag, " rsp_error"}, 32'(rsp_error), 32'(got.error));
        end
      end
    end
    if (!seen) check_eq({tag, " rsp timeout"}, 32'd0, 32'd1);
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, " rsp one-shot"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst req_ready", 32'(req_ready), 32'd1);
    check_eq("rst mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst mem_we", 32'(mem_we), 32'd0);
    check_eq("rst mem_addr", mem_addr, 32'h0);
    check_eq("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
    check_eq("rst mem_wdata", mem_wdata, 32'h0);
    check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst rsp_error", 32'(rsp_error), 32'd0);

    //       tag    we    f3      addr          wdata          rdata         dly wstrb    wdata_exp      rdata_exp     err
    run_txn("LW",   1'b0, 3'b010, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0);
    run_txn("LB",   1'b0, 3'b000, 32'h0000_2003, 32'h0,        32'h80FF_1234, 0, 4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0);
    run_txn("LBU",  1'b0, 3'b100, 32'h0000_2003, 32'h0,        32'h80FF_1234, 1, 4'b0000, 32'h0,         32'h0000_0080, 1'b0);
    run_txn("LB1",  1'b0, 3'b000, 32'h0000_2001, 32'h0,        32'h80FF_1234, 0, 4'b0000, 32'h0,         32'h0000_0012, 1'b0);
    run_txn("LH",   1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h80FF_1234, 0, 4'b0000, 32'h0,         32'hFFFF_80FF, 1'b0);
    run_txn("LHU",  1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h80FF_1234, 0, 4'b0000, 32'h0,         32'h0000_80FF, 1'b0);
    run_txn("LH0",  1'b0, 3'b001, 32'h0000_2000, 32'h0,        32'h80FF_9234, 0, 4'b0000, 32'h0,         32'hFFFF_9234, 1'b0);
    run_txn("SB",   1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'hFFFF_FFFF, 3, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0);
    run_txn("SH",   1'b1, 3'b001, 32'h0000_3002, 32'h1234_56AB, 32'hFFFF_FFFF, 3, 4'b1100, 32'h56AB_56AB, 32'h0,        1'b0);
    run_txn("SW",   1'b1, 3'b010, 32'h0000_3008, 32'h1234_56AB, 32'hFFFF_FFFF, 0, 4'b1111, 32'h1234_56AB, 32'h0,        1'b0);
    run_txn("ELW",  1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'hFFFF_FFFF, 0, 4'b0000, 32'h0,         32'h0,         1'b1);
    run_txn("ELH",  1'b0, 3'b001, 32'h0000_4001, 32'h0,        32'hFFFF_FFFF, 0, 4'b0000, 32'h0,         32'h0,         1'b1);
    run_txn("EF3",  1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'hFFFF_FFFF, 0, 4'b0000, 32'h0,         32'h0,         1'b1);
    run_txn("ESB",  1'b1, 3'b100, 32'h0000_4000, 32'h0,        32'hFFFF_FFFF, 0, 4'b0000, 32'h0,         32'h0,         1'b1);

    // Reset while BUSY: mem_valid must drop without waiting for a clock edge.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_5000;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rstbusy mem_valid pre", 32'(mem_valid), 32'd1);
    #1 rst = 1'b1;
    #1 check_eq("rstbusy mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rstbusy req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rstbusy no rsp", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstbusy idle rsp", 32'(rsp_valid), 32'd0);
    run_txn("LWpost", 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 1, 4'b0000, 32'h0,
            32'h0BAD_F00D, 1'b0);

    check_eq("scoreboard empty", 32'(rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
